// File: rtl/vga_overlay_pkg.sv
// vga_overlay_pkg: overlay register map shared by feeder and overlay, plus feeder FSM states
package vga_overlay_pkg;
  localparam logic [7:0] ADDR_SEG_RELOJ = 8'd40;
  localparam logic [7:0] ADDR_MIN_RELOJ = 8'd41;
  localparam logic [7:0] ADDR_HOR_RELOJ = 8'd42;
  localparam logic [7:0] ADDR_DIA_FECHA = 8'd43;
  localparam logic [7:0] ADDR_MES_FECHA = 8'd44;
  localparam logic [7:0] ADDR_ANO_FECHA = 8'd45;
  localparam logic [7:0] ADDR_SEG_CRONO = 8'd46;
  localparam logic [7:0] ADDR_MIN_CRONO = 8'd47;
  localparam logic [7:0] ADDR_HOR_CRONO = 8'd48;
  localparam logic [7:0] ADDR_CURSOR    = 8'd49;
  localparam logic [7:0] ADDR_FLAGS     = 8'd50;
  localparam logic [7:0] ADDR_ACT_CRONO = 8'd51;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DONE} feeder_state_t;
endpackage

// File: rtl/vga_vsync_edge.sv
// vga_vsync_edge: falling-edge detect of the active-low VSync pulse
module vga_vsync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic fall
);
  logic vs_d, armed;
  assign fall = armed & vs_d & ~vsync;
  // armed is loaded from VSync during reset so a pulse already low at release is ignored
  always_ff @(posedge clk)
    if (rst) begin
      vs_d  <= 1'b1;
      armed <= vsync;
    end else begin
      vs_d  <= vsync;
      armed <= armed | vsync;
    end
endmodule

// File: rtl/vga_shadow_feeder.sv
// vga_shadow_feeder: sweeps RTC registers to the overlay during VSync; VGA_FEEDER_CHANGE_FILTER_EN drops unchanged writes
module vga_shadow_feeder
  import vga_overlay_pkg::*;
#(
  parameter int BASE_ADDR = ADDR_SEG_RELOJ,
  parameter int NUM_REGS  = 12,
  parameter int READ_LAT  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VSync,
  input  logic       RamBusy,
  input  logic [7:0] RamData,
  output logic       RamRd,
  output logic [7:0] RamAddr,
  output logic [7:0] MemAddrOUT,
  output logic [7:0] MemDataOUT,
  output logic       Write,
  output logic       FrameDone
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  feeder_state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0] lat, lat_n;
  logic rd_n, wr_n, fd_n, start, abort, changed;
  logic [7:0] ra_n, ma_n, md_n, cur;
  vga_vsync_edge u_edge (.clk(CLK), .rst(RESET), .vsync(VSync), .fall(start));
  assign cur = 8'(BASE_ADDR) + 8'(idx);
  assign abort = VSync && state != IDLE && state != DONE;
`ifdef VGA_FEEDER_CHANGE_FILTER_EN
  logic [7:0] shadow [NUM_REGS];
  assign changed = RamData != shadow[idx];
  // shadow tracks the last value pushed so only changed registers strobe
  always_ff @(posedge CLK)
    if (RESET) shadow <= '{default: 8'd0};
    else if (state == PUSH && !abort) shadow[idx] <= RamData;
`else
  assign changed = 1'b1;
`endif
  // next state and next values of the registered outputs; an abort cancels everything
  always_comb begin
    state_n = state;
    idx_n = idx;
    lat_n = lat;
    rd_n = 1'b0;
    ra_n = RamAddr;
    wr_n = 1'b0;
    ma_n = MemAddrOUT;
    md_n = MemDataOUT;
    fd_n = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = REQ;
        idx_n = '0;
      end
      REQ: if (!RamBusy) begin
        state_n = WAIT;
        rd_n = 1'b1;
        ra_n = cur;
        lat_n = 2'(READ_LAT);
      end
      WAIT: begin
        lat_n = lat - 2'd1;
        state_n = lat == 2'd1 ? PUSH : WAIT;
      end
      PUSH: begin
        wr_n = changed;
        ma_n = changed ? cur : MemAddrOUT;
        md_n = changed ? RamData : MemDataOUT;
        fd_n = idx == IW'(NUM_REGS - 1);
        state_n = fd_n ? DONE : REQ;
        idx_n = fd_n ? idx : idx + IW'(1);
      end
      DONE: if (VSync) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      rd_n = 1'b0;
      ra_n = RamAddr;
      wr_n = 1'b0;
      ma_n = MemAddrOUT;
      md_n = MemDataOUT;
      fd_n = 1'b0;
    end
  end
  // state and registered outputs
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      idx <= '0;
      lat <= '0;
      RamRd <= 1'b0;
      RamAddr <= '0;
      Write <= 1'b0;
      MemAddrOUT <= '0;
      MemDataOUT <= '0;
      FrameDone <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      lat <= lat_n;
      RamRd <= rd_n;
      RamAddr <= ra_n;
      Write <= wr_n;
      MemAddrOUT <= ma_n;
      MemDataOUT <= md_n;
      FrameDone <= fd_n;
    end
endmodule
